// File: rtl/cmd_stage_queue_if.sv
// rtl/cmd_stage_queue_if.sv - loader write channel and issuer read channel of the command stage queue
interface cmd_stage_queue_if #(
    parameter int CMD_W = 64
);
    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [CMD_W-1:0] i_wr_cmd;
    logic             i_wr_barrier;
    logic             i_rd;
    logic [CMD_W-1:0] o_cmd;
    logic             o_empty;

    modport master (
        output i_wr_valid, i_wr_cmd, i_wr_barrier, i_rd,
        input  o_wr_ready, o_cmd, o_empty
    );

    modport slave (
        input  i_wr_valid, i_wr_cmd, i_wr_barrier, i_rd,
        output o_wr_ready, o_cmd, o_empty
    );
endinterface

// File: rtl/cmd_stage_queue.sv
// rtl/cmd_stage_queue.sv - command FIFO with stage barriers; optional stats via CMD_STAGE_QUEUE_STATS_EN
module cmd_stage_queue #(
    parameter int CMD_W     = 64,
    parameter int DEPTH     = 512,
    parameter int BAR_DEPTH = 4,
    parameter int SETTLE    = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    cmd_stage_queue_if.slave  q,
    input  logic              i_finished_task,
    output logic [7:0]        o_stage_idx,
    output logic [AW:0]       o_count,
    output logic              o_idle
`ifdef CMD_STAGE_QUEUE_STATS_EN
    ,
    output logic [31:0]       o_stall_cycles,
    output logic [AW:0]       o_hwm
`endif
);
    localparam int BW = $clog2(BAR_DEPTH);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic {
        ST_RUN,
        ST_WAIT_DONE
    } state_t;

    // Storage arrays carry no reset; pointers alone define validity.
    logic [CMD_W-1:0] mem     [DEPTH];
    logic [AW:0]      bar_mem [BAR_DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [BW:0] bar_wp_q, bar_wp_d;
    logic [BW:0] bar_rp_q, bar_rp_d;
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]  stage_q, stage_d;

    logic [AW:0] count;
    logic        full;
    logic        bar_empty;
    logic        bar_full;
    logic [AW:0] bar_head;
    logic [AW:0] lim;
    logic        empty;
    logic        wr_fire;
    logic        pop;
    logic        bar_push;

    // Queue status derived only from registered pointers and state.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        bar_empty = (bar_wp_q == bar_rp_q);
        bar_full  = (bar_wp_q[BW] != bar_rp_q[BW]) && (bar_wp_q[BW-1:0] == bar_rp_q[BW-1:0]);
        bar_head  = bar_mem[bar_rp_q[BW-1:0]];
        // Commands at or past the oldest open barrier stay hidden from the issuer.
        lim       = bar_empty ? wr_ptr_q : bar_head;
        empty     = (rd_ptr_q == lim) || (state_q != ST_RUN);
        wr_fire   = q.i_wr_valid && !full && !bar_full;
        pop       = q.i_rd && !empty;
        bar_push  = wr_fire && q.i_wr_barrier;
    end

    assign q.o_wr_ready = !full && !bar_full;
    assign q.o_empty    = empty;
    assign q.o_cmd      = mem[rd_ptr_q[AW-1:0]];
    assign o_stage_idx  = stage_q;
    assign o_count      = count;
    assign o_idle       = (count == '0) && (state_q == ST_RUN);

    // Next-state: pointer updates and the stage barrier FSM.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        bar_wp_d = bar_wp_q;
        bar_rp_d = bar_rp_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;

        if (wr_fire) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (bar_push) bar_wp_d = bar_wp_q + (BW+1)'(1);

        case (state_q)
            ST_RUN: begin
                // Stage fully issued once the read pointer reaches the barrier.
                if (!bar_empty && (rd_ptr_d == bar_head)) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_DONE: begin
                // Settle window masks a finished flag left high from the previous stage.
                if (cnt_q != CW'(SETTLE)) cnt_d = cnt_q + CW'(1);
                if ((cnt_q == CW'(SETTLE)) && i_finished_task) begin
                    bar_rp_d = bar_rp_q + (BW+1)'(1);
                    stage_d  = stage_q + 8'd1;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            bar_wp_q <= '0;
            bar_rp_q <= '0;
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            stage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            bar_wp_q <= bar_wp_d;
            bar_rp_q <= bar_rp_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stage_q  <= stage_d;
        end
    end

    // Command storage write port.
    always_ff @(posedge i_clk) begin
        if (wr_fire) mem[wr_ptr_q[AW-1:0]] <= q.i_wr_cmd;
    end

    // Barrier FIFO records the pointer just past each stage's last command.
    always_ff @(posedge i_clk) begin
        if (bar_push) bar_mem[bar_wp_q[BW-1:0]] <= wr_ptr_q + (AW+1)'(1);
    end

`ifdef CMD_STAGE_QUEUE_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [AW:0] hwm_q, hwm_d;

    always_comb begin
        stall_d = stall_q;
        hwm_d   = hwm_q;
        if ((state_q == ST_WAIT_DONE) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
        if (count > hwm_q) hwm_d = count;
    end

    // Stall-cycle and occupancy high-water-mark statistics.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            stall_q <= '0;
            hwm_q   <= '0;
        end else begin
            stall_q <= stall_d;
            hwm_q   <= hwm_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_hwm          = hwm_q;
`endif
endmodule

// File: tb/tb_cmd_stage_queue.sv
// tb/tb_cmd_stage_queue.sv - directed self-checking bench for cmd_stage_queue
module tb_cmd_stage_queue;
    localparam int CMD_W = 64;
    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk;
    logic          rstn;
    logic          finished;
    logic [7:0]    stage_idx;
    logic [AW:0]   count;
    logic          idle;
`ifdef CMD_STAGE_QUEUE_STATS_EN
    logic [31:0]   stall_cycles;
    logic [AW:0]   hwm;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    cmd_stage_queue_if #(.CMD_W(CMD_W)) bus ();

    cmd_stage_queue #(
        .CMD_W(CMD_W), .DEPTH(DEPTH), .BAR_DEPTH(4), .SETTLE(2)
    ) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .q               (bus.slave),
        .i_finished_task (finished),
        .o_stage_idx     (stage_idx),
        .o_count         (count),
        .o_idle          (idle)
`ifdef CMD_STAGE_QUEUE_STATS_EN
        ,
        .o_stall_cycles  (stall_cycles),
        .o_hwm           (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [63:0] c, input logic b);
        bus.i_wr_valid   = 1'b1;
        bus.i_wr_cmd     = c;
        bus.i_wr_barrier = b;
        step();
        bus.i_wr_valid   = 1'b0;
        bus.i_wr_barrier = 1'b0;
    endtask

    task automatic pop1();
        bus.i_rd = 1'b1;
        step();
        bus.i_rd = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_abc [3];
        logic [63:0] exp_v;
        int          bad;

        rstn             = 1'b0;
        finished         = 1'b0;
        bus.i_wr_valid   = 1'b0;
        bus.i_wr_cmd     = '0;
        bus.i_wr_barrier = 1'b0;
        bus.i_rd         = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();

        // 1: reset state
        check("rst_empty", bus.o_empty, 1);
        check("rst_ready", bus.o_wr_ready, 1);
        check("rst_count", count, 0);
        check("rst_stage", stage_idx, 0);
        check("rst_idle", idle, 1);

        // 2: plain FIFO order, first write visible the next cycle
        wr(64'hA, 1'b0);
        check("t2_visible", bus.o_empty, 0);
        wr(64'hB, 1'b0);
        wr(64'hC, 1'b0);
        check("t2_count3", count, 3);
        exp_abc[0] = 64'hA; exp_abc[1] = 64'hB; exp_abc[2] = 64'hC;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_cmd%0d", i), bus.o_cmd, exp_abc[i]);
            pop1();
        end
        check("t2_empty", bus.o_empty, 1);
        check("t2_count0", count, 0);
        pop1();
        check("t2_no_underflow", count, 0);

        // 3: barrier on 2nd command, stale finished flag held high
        wr(64'h1, 1'b0);
        wr(64'h2, 1'b1);
        wr(64'h3, 1'b0);
        wr(64'h4, 1'b0);
        wr(64'h5, 1'b0);
        wr(64'h6, 1'b0);
        finished = 1'b1;
        bus.i_rd = 1'b1;
        check("t3_cmd1", bus.o_cmd, 64'h1);
        step();
        check("t3_cmd2", bus.o_cmd, 64'h2);
        check("t3_vis2", bus.o_empty, 0);
        step();
        check("t3_wait_empty0", bus.o_empty, 1);
        check("t3_wait_count", count, 4);
        check("t3_wait_idle", idle, 0);
        step();
        check("t3_wait_empty1", bus.o_empty, 1);
        step();
        check("t3_wait_empty2", bus.o_empty, 1);
        check("t3_wait_stage", stage_idx, 0);
        step();
        check("t3_released", bus.o_empty, 0);
        check("t3_stage1", stage_idx, 1);
        check("t3_cmd3", bus.o_cmd, 64'h3);
        step();
        check("t3_cmd4", bus.o_cmd, 64'h4);
        step();
        check("t3_cmd5", bus.o_cmd, 64'h5);
        step();
        check("t3_cmd6", bus.o_cmd, 64'h6);
        step();
        bus.i_rd = 1'b0;
        finished = 1'b0;
        check("t3_drained", count, 0);
        check("t3_idle", idle, 1);
`ifdef CMD_STAGE_QUEUE_STATS_EN
        check("t3_stall", stall_cycles, 3);
`endif

        // 4: fill, overflow attempt, simultaneous write/pop, wrap with order kept
        bus.i_wr_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus.i_wr_cmd = 64'h1000 + 64'(i);
            step();
        end
        bus.i_wr_valid = 1'b0;
        check("t4_full_count", count, 512);
        check("t4_full_ready", bus.o_wr_ready, 0);
        wr(64'hDEAD, 1'b0);
        check("t4_ovf_count", count, 512);
        check("t4_ovf_head", bus.o_cmd, 64'h1000);
`ifdef CMD_STAGE_QUEUE_STATS_EN
        check("t4_hwm", hwm, 512);
`endif
        pop1();
        check("t4_pop_count", count, 511);
        check("t4_pop_ready", bus.o_wr_ready, 1);
        bus.i_rd = 1'b1;
        wr(64'h2000, 1'b0);
        bus.i_rd = 1'b0;
        check("t4_wrpop_count", count, 511);
        wr(64'h2001, 1'b0);
        check("t4_refill", count, 512);
        bad = 0;
        bus.i_rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            exp_v = (i < 510) ? 64'h1002 + 64'(i) : 64'h2000 + 64'(i - 510);
            if (bus.o_cmd !== exp_v || bus.o_empty !== 1'b0) bad++;
            step();
        end
        bus.i_rd = 1'b0;
        check("t4_order_errors", 64'(bad), 0);
        check("t4_drained", count, 0);

        // 5: barrier FIFO full blocks writes until a stage completes
        wr(64'h50, 1'b1);
        wr(64'h51, 1'b1);
        wr(64'h52, 1'b1);
        wr(64'h53, 1'b1);
        check("t5_barfull_ready", bus.o_wr_ready, 0);
        wr(64'h54, 1'b0);
        check("t5_barfull_count", count, 4);
        check("t5_head", bus.o_cmd, 64'h50);
        pop1();
        check("t5_wait", bus.o_empty, 1);
        finished = 1'b1;
        for (int k = 0; k < 10 && bus.o_empty; k++) step();
        check("t5_released", bus.o_empty, 0);
        check("t5_ready", bus.o_wr_ready, 1);
        check("t5_stage2", stage_idx, 2);
        check("t5_cmd", bus.o_cmd, 64'h51);
        finished = 1'b0;

        // 6: asynchronous reset while waiting with 10 entries stored
        for (int i = 0; i < 8; i++) wr(64'h60 + 64'(i), 1'b0);
        pop1();
        step(); step(); step();
        check("t6_pre_empty", bus.o_empty, 1);
        check("t6_pre_count", count, 10);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_empty", bus.o_empty, 1);
        check("t6_rst_stage", stage_idx, 0);
        check("t6_rst_idle", idle, 1);
`ifdef CMD_STAGE_QUEUE_STATS_EN
        check("t6_rst_stall", stall_cycles, 0);
`endif
        step();
        rstn = 1'b1;
        step();
        check("t6_post_ready", bus.o_wr_ready, 1);
        wr(64'h77, 1'b0);
        check("t6_post_visible", bus.o_empty, 0);
        check("t6_post_cmd", bus.o_cmd, 64'h77);
        check("t6_post_count", count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
